// File: rtl/calc_seq_core_if.sv
// Operator-panel bus for calc_seq_core.
//   master (panel/testbench): drives enter_pulse, clear_pulse, operand_in, op_sel;
//                             observes result, sign, err, busy, done, display_sel, state_led.
//   slave  (calc_seq_core):   the mirror image.
interface calc_seq_core_if #(
  parameter int unsigned WIDTH = 20
);
  logic             enter_pulse;
  logic             clear_pulse;
  logic [WIDTH-1:0] operand_in;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] result;
  logic             sign;
  logic             err;
  logic             busy;
  logic             done;
  logic [1:0]       display_sel;
  logic [2:0]       state_led;

  modport master (
    output enter_pulse, clear_pulse, operand_in, op_sel,
    input  result, sign, err, busy, done, display_sel, state_led
  );

  modport slave (
    input  enter_pulse, clear_pulse, operand_in, op_sel,
    output result, sign, err, busy, done, display_sel, state_led
  );
endinterface

// File: rtl/calc_seq_core.sv
// Sequential signed-magnitude decimal-range calculator core.
// Operand A is entered, then operand B together with the operation; the core computes
// add/sub in one cycle, mul (shift-add) and div/mod (restoring division) in WIDTH cycles,
// and shows the result or an error. A shown result can be chained as the next operand A.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    calc_seq_core_if.slave: enter/clear strobes, operand, op select in;
//          result, sign, err, busy, done pulse, display_sel, one-hot state_led out
module calc_seq_core #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned WIDTH  = 20
) (
  input logic            clk,
  input logic            rst_n,
  calc_seq_core_if.slave bus
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpDiv = 3'd3;
  localparam logic [2:0] OpMod = 3'd4;

  // Largest magnitude representable on the decimal display.
  localparam logic [WIDTH-1:0]   Max     = WIDTH'(10 ** DIGITS - 1);
  localparam logic [2*WIDTH-1:0] MaxWide = {{WIDTH{1'b0}}, Max};
  localparam int unsigned        CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]    LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StA,
    StB,
    StRun,
    StShow,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d;
  logic               a_sign_q, a_sign_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // acc: mul partial product / div partial remainder (low WIDTH bits).
  // work: mul multiplier shifting right / div dividend shifting out, quotient shifting in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   work_q, work_d;

  // ---------------------------------------------------------------------------
  // Arithmetic step logic
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     a_ext, b_ext, as_mag;
  logic               as_sign, b_neg;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift, div_rem;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_quot;

  always_comb begin
    a_ext = {1'b0, a_q};
    b_ext = {1'b0, b_q};
    // Subtraction is addition of a negated B; B itself is always entered positive.
    b_neg = (op_q == OpSub);
    if (a_sign_q == b_neg) begin
      as_mag  = a_ext + b_ext;
      as_sign = a_sign_q;
    end else if (a_q >= b_q) begin
      as_mag  = a_ext - b_ext;
      as_sign = a_sign_q;
    end else begin
      as_mag  = b_ext - a_ext;
      as_sign = b_neg;
    end

    mul_acc = work_q[0] ? (acc_q + mcand_q) : acc_q;

    div_shift = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
    div_qbit  = (div_shift >= b_ext);
    div_rem   = div_qbit ? (div_shift - b_ext) : div_shift;
    div_quot  = {work_q[WIDTH-2:0], div_qbit};
  end

  // Completion of the current S_RUN cycle and the value it produces.
  logic               fin, fin_err, fin_sign;
  logic [2*WIDTH-1:0] fin_mag;

  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_sign = a_sign_q;
    fin_mag  = '0;
    if (state_q == StRun) begin
      unique case (op_q)
        OpAdd, OpSub: begin
          fin      = 1'b1;
          fin_mag  = {{(WIDTH-1){1'b0}}, as_mag};
          fin_sign = as_sign;
        end
        OpMul: begin
          fin     = (cnt_q == LastCnt);
          fin_mag = mul_acc;
        end
        OpDiv, OpMod: begin
          // Division by zero aborts on the first run cycle.
          if (b_q == '0) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            fin = (cnt_q == LastCnt);
          end
          fin_mag = (op_q == OpDiv) ? {{WIDTH{1'b0}}, div_quot}
                                    : {{(WIDTH-1){1'b0}}, div_rem};
        end
        default: begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      endcase
      if (fin_mag > MaxWide) begin
        fin_err = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StA;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.clear_pulse) begin
      state_d = StA;
    end else begin
      unique case (state_q)
        StA: begin
          if (bus.enter_pulse) begin
            state_d = (bus.operand_in > Max) ? StErr : StB;
          end
        end
        StB: begin
          if (bus.enter_pulse) begin
            state_d = ((bus.operand_in > Max) || (bus.op_sel > OpMod)) ? StErr : StRun;
          end
        end
        StRun: begin
          if (fin) begin
            state_d = fin_err ? StErr : StShow;
          end
        end
        StShow: begin
          if (bus.enter_pulse) begin
            state_d = StB;
          end
        end
        StErr:   state_d = StErr;
        default: state_d = StA;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy        = 1'b0;
    bus.err         = 1'b0;
    bus.display_sel = 2'd0;
    bus.state_led   = 3'b000;
    unique case (state_q)
      StA: begin
        bus.display_sel = 2'd0;
        bus.state_led   = 3'b001;
      end
      StB: begin
        bus.display_sel = 2'd1;
        bus.state_led   = 3'b010;
      end
      StRun: begin
        bus.busy        = 1'b1;
        bus.display_sel = 2'd2;
      end
      StShow: begin
        bus.display_sel = 2'd3;
        bus.state_led   = 3'b100;
      end
      StErr: begin
        bus.err         = 1'b1;
        bus.display_sel = 2'd3;
      end
      default: begin
        bus.display_sel = 2'd0;
      end
    endcase
  end

  assign bus.result = result_q;
  assign bus.sign   = sign_q;
  assign bus.done   = done_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    a_sign_d = a_sign_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    work_d   = work_q;
    cnt_d    = (state_q == StRun) ? cnt_q + 1'b1 : '0;
    // done fires only on the edge that enters a terminal state.
    done_d   = ((state_d == StShow) || (state_d == StErr)) && (state_d != state_q);

    if (bus.clear_pulse) begin
      a_d      = '0;
      a_sign_d = 1'b0;
      b_d      = '0;
      op_d     = OpAdd;
      result_d = '0;
      sign_d   = 1'b0;
      acc_d    = '0;
      mcand_d  = '0;
      work_d   = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StA: begin
          if (bus.enter_pulse) begin
            a_d      = bus.operand_in;
            a_sign_d = 1'b0;
          end
        end
        StB: begin
          if (bus.enter_pulse) begin
            b_d     = bus.operand_in;
            op_d    = bus.op_sel;
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a_q};
            // Mul shifts the multiplier B; div/mod shifts the dividend A.
            work_d  = (bus.op_sel == OpMul) ? bus.operand_in : a_q;
          end
        end
        StRun: begin
          if (op_q == OpMul) begin
            acc_d   = mul_acc;
            mcand_d = mcand_q << 1;
            work_d  = work_q >> 1;
          end else begin
            acc_d  = {{(WIDTH-1){1'b0}}, div_rem};
            work_d = div_quot;
          end
          if (fin) begin
            result_d = fin_err ? '0 : fin_mag[WIDTH-1:0];
            sign_d   = fin_err ? 1'b0 : (fin_sign && (fin_mag != '0));
          end
        end
        StShow: begin
          if (bus.enter_pulse) begin
            a_d      = result_q;
            a_sign_d = sign_q;
          end
        end
        StErr: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      a_sign_q <= 1'b0;
      b_q      <= '0;
      op_q     <= OpAdd;
      result_q <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      work_q   <= '0;
    end else begin
      a_q      <= a_d;
      a_sign_q <= a_sign_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      work_q   <= work_d;
    end
  end

endmodule

// File: tb/tb_calc_seq_core.sv
module tb_calc_seq_core;

  localparam int unsigned WIDTH = 20;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpDiv = 3'd3;
  localparam logic [2:0] OpMod = 3'd4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  calc_seq_core_if #(.WIDTH(WIDTH)) bus ();

  calc_seq_core #(
    .DIGITS(6),
    .WIDTH (WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [19:0] res;
    logic        sgn;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   tag_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_val(input int unsigned r, input logic s);
    exp_q.push_back('{tag: tag_n, res: 20'(r), sgn: s, er: 1'b0});
    tag_n++;
  endtask

  task automatic expect_err();
    exp_q.push_back('{tag: tag_n, res: 20'd0, sgn: 1'b0, er: 1'b1});
    tag_n++;
  endtask

  // Scoreboard monitor: every done pulse consumes one expected response.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, required no done pulse");
      end else begin
        sb_e = exp_q.pop_front();
        check($sformatf("sb%0d_err", sb_e.tag), 32'(bus.err), 32'(sb_e.er));
        if (!sb_e.er) begin
          check($sformatf("sb%0d_result", sb_e.tag), 32'(bus.result), 32'(sb_e.res));
          check($sformatf("sb%0d_sign", sb_e.tag), 32'(bus.sign), 32'(sb_e.sgn));
        end
      end
    end
  end

  task automatic pulse_enter(input int unsigned val, input logic [2:0] op);
    bus.operand_in  = 20'(val);
    bus.op_sel      = op;
    bus.enter_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.enter_pulse = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_pulse = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles on the way.
  task automatic run_wait(input string name, input int exp_busy);
    int nb   = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nb++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  task automatic check_idle(input string name);
    check({name, "_result"}, 32'(bus.result), 32'd0);
    check({name, "_sign"}, 32'(bus.sign), 32'd0);
    check({name, "_err"}, 32'(bus.err), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
    check({name, "_display_sel"}, 32'(bus.display_sel), 32'd0);
    check({name, "_state_led"}, 32'(bus.state_led), 32'b001);
  endtask

  initial begin
    int nb;
    rst_n           = 1'b0;
    bus.enter_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.operand_in  = '0;
    bus.op_sel      = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 123 + 456
    pulse_enter(123, OpAdd);
    check("after_a_display_sel", 32'(bus.display_sel), 32'd1);
    check("after_a_state_led", 32'(bus.state_led), 32'b010);
    expect_val(579, 1'b0);
    pulse_enter(456, OpAdd);
    run_wait("add", 1);
    check("add_display_sel", 32'(bus.display_sel), 32'd3);
    check("add_state_led", 32'(bus.state_led), 32'b100);
    @(negedge clk);
    check("add_done_one_cycle", 32'(bus.done), 32'd0);

    // 5 - 12 = -7, then chain: *2 = -14, mod 4 = -2, +2 = 0 (sign forced 0)
    pulse_clear();
    pulse_enter(5, OpAdd);
    expect_val(7, 1'b1);
    pulse_enter(12, OpSub);
    run_wait("sub", 1);
    pulse_enter(0, OpAdd);
    check("chain_display_sel", 32'(bus.display_sel), 32'd1);
    expect_val(14, 1'b1);
    pulse_enter(2, OpMul);
    run_wait("neg_mul", 20);
    pulse_enter(0, OpAdd);
    expect_val(2, 1'b1);
    pulse_enter(4, OpMod);
    run_wait("neg_mod", 20);
    pulse_enter(0, OpAdd);
    expect_val(0, 1'b0);
    pulse_enter(2, OpAdd);
    run_wait("zero_sum", 1);

    // 1000 * 1000 overflows after the full iteration
    pulse_clear();
    pulse_enter(1000, OpAdd);
    expect_err();
    pulse_enter(1000, OpMul);
    run_wait("mul_ovf", 20);
    check("mul_ovf_err", 32'(bus.err), 32'd1);
    pulse_enter(7, OpAdd);
    check("err_enter_ignored_err", 32'(bus.err), 32'd1);
    check("err_enter_ignored_disp", 32'(bus.display_sel), 32'd3);
    pulse_clear();
    #4;
    check_idle("err_clear");

    // Division by zero is flagged on the first run cycle
    pulse_enter(100, OpAdd);
    expect_err();
    pulse_enter(0, OpDiv);
    run_wait("div0", 1);

    // 17 mod 5 = 2, chain * 3 = 6
    pulse_clear();
    pulse_enter(17, OpAdd);
    expect_val(2, 1'b0);
    pulse_enter(5, OpMod);
    run_wait("mod", 20);
    pulse_enter(0, OpAdd);
    expect_val(6, 1'b0);
    pulse_enter(3, OpMul);
    run_wait("chain_mul", 20);

    // Display limit: 999999 fits, 999999 + 1 does not
    pulse_clear();
    pulse_enter(999999, OpAdd);
    expect_val(999999, 1'b0);
    pulse_enter(0, OpAdd);
    run_wait("max_add", 1);
    pulse_enter(0, OpAdd);
    expect_err();
    pulse_enter(1, OpAdd);
    run_wait("max_ovf", 1);

    // Operand above the limit, and a reserved op_sel, at latch time
    pulse_clear();
    expect_err();
    pulse_enter(1000000, OpAdd);
    run_wait("a_too_big", 0);
    pulse_clear();
    pulse_enter(3, OpAdd);
    expect_err();
    pulse_enter(4, 3'd5);
    run_wait("reserved_op", 0);

    // Clear on the 5th busy cycle aborts without a done pulse
    pulse_clear();
    pulse_enter(999, OpAdd);
    pulse_enter(999, OpMul);
    nb = 0;
    for (int i = 0; i < 10 && nb < 5; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nb++;
    end
    check("abort_busy_reached", 32'(nb), 32'd5);
    pulse_clear();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_display_sel", 32'(bus.display_sel), 32'd0);
    repeat (25) @(negedge clk);
    check("abort_state_led", 32'(bus.state_led), 32'b001);

    // Clear and enter together in S_B: clear wins
    pulse_enter(4, OpAdd);
    bus.operand_in  = 20'd5;
    bus.op_sel      = OpAdd;
    bus.enter_pulse = 1'b1;
    bus.clear_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.enter_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    check("clr_enter_display_sel", 32'(bus.display_sel), 32'd0);
    repeat (3) @(negedge clk);
    check("clr_enter_state_led", 32'(bus.state_led), 32'b001);

    // Asynchronous reset in the middle of a division
    pulse_enter(17, OpAdd);
    expect_val(22, 1'b0);
    pulse_enter(5, OpAdd);
    run_wait("pre_reset_add", 1);
    pulse_enter(0, OpAdd);
    pulse_enter(7, OpDiv);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back to normal operation: 8 / 3 = 2
    pulse_enter(8, OpAdd);
    expect_val(2, 1'b0);
    pulse_enter(3, OpDiv);
    run_wait("post_reset_div", 20);

    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
